contador_16b: RTL and testbench
===============================

# contador_16b

Modal 16-bit up/down counter built as four cascaded 4-bit stages, each with its own ripple-carry-out flag. Each cycle it counts up by 1, counts down by 1, counts down by 3, or loads a parallel value, as selected by `MODO`. It is the counting datapath of the counter subsystem. Software-visible state is `salida` plus the four per-stage carry flags.

## Interface
Parameters: none (width fixed at 16 bits, 4 stages of 4 bits).

Ports:
- `CLK` in 1: single clock; all state updates on rising edge.
- `RESET_L` in 1: one clock; reset is asynchronous and active-low.
- `ENB` in 1: count/load enable; low = hold.
- `MODO` in 2: operation select (see Operation).
- `entrada` in 16: parallel load value.
- `salida` out 16: registered count value.
- `RCO` out 1: carry/borrow out of stage 0 (bits 3:0), registered.
- `RCO162` out 1: carry/borrow out of stage 1 (bits 7:0), registered.
- `RCO163` out 1: carry/borrow out of stage 2 (bits 11:0), registered.
- `RCO164` out 1: carry/borrow out of stage 3 (full 16-bit wrap), registered.

## Operation
- `RESET_L`=0 forces `salida`=16'h0000 and all four RCO flags to 0 immediately, regardless of `CLK`. State is held there while `RESET_L` is low.
- Each rising `CLK` with `RESET_L`=1 and `ENB`=1 performs one operation:
  - `MODO`=00: `salida` <= `salida` + 1, modulo 2^16.
  - `MODO`=01: `salida` <= `salida` - 1, modulo 2^16.
  - `MODO`=10: `salida` <= `salida` - 3, modulo 2^16.
  - `MODO`=11: `salida` <= `entrada`.
- The cascade is arithmetically exact. A carry or borrow out of a stage propagates into the next stage in the same cycle, so the 16-bit result always equals the full-width modular arithmetic.
- RCO flags are updated on the same edge as `salida`:
  - RCO of stage k (k=0..3) is set to 1 iff the operation carried out of, or borrowed into, bit position 4(k+1).
  - Up by 1: stage k flag = 1 iff old `salida[4k+3:0]` is all ones.
  - Down by 1: stage k flag = 1 iff old `salida[4k+3:0]` is all zeros.
  - Down by 3: stage k flag = 1 iff old `salida[4k+3:0]` < 3.
  - Load (`MODO`=11): all flags <= 0.
- `ENB`=0 on an edge: `salida` holds; all RCO flags <= 0. Flags are one-cycle pulses and never persist.
- Flags are nested by construction: `RCO164` implies `RCO163`, which implies `RCO162`, which implies `RCO`.

## Timing
- Latency 1 cycle: inputs sampled at edge n are reflected on `salida` and RCO flags after edge n. There is no combinational path from inputs to outputs.
- `MODO` and `entrada` may change freely between edges; only their values at the rising edge matter.
- Reset deassertion takes effect on the first rising edge after `RESET_L` goes high. The first operation uses `salida`=0.
- Reset asserted mid-count clears all outputs asynchronously. The count does not resume from its pre-reset value.
- Wrap-around:
  - 16'hFFFF +1 → 16'h0000 with all four flags = 1.
  - 16'h0000 -1 → 16'hFFFF with all four flags = 1.
  - 16'h0001 -3 → 16'hFFFE with all four flags = 1.
- A load of any value, including 16'hFFFF or 16'h0000, never raises a flag.

## Test plan
- Reset: drive `RESET_L`=0 asynchronously mid-cycle with `salida`=16'h5A5A → `salida`=16'h0000 and all RCO=0 before the next edge. Values stay there while reset is held.
- Load then count up: load 16'h00FF (`MODO`=11), then one edge with `MODO`=00 → `salida`=16'h0100, `RCO`=1, `RCO162`=1, `RCO163`=0, `RCO164`=0. Next edge → 16'h0101 with all flags 0.
- Full up-wrap: load 16'hFFFF, `MODO`=00 → 16'h0000 with all four flags = 1. Load 16'hFFFF itself → all flags 0.
- Down by 1 and down by 3:
  - Load 16'h0000, `MODO`=01 → 16'hFFFF with all flags 1.
  - Load 16'h0010, `MODO`=10 → 16'h000D with `RCO`=1 and others 0.
  - Load 16'h0002, `MODO`=10 → 16'hFFFF with all flags 1.
- Enable hold: load 16'h1234, set `ENB`=0 for 5 edges in each `MODO` → `salida` stays 16'h1234 and flags stay 0. Re-enable with `MODO`=00 → 16'h1235.
- Reset mid-count: count up from 16'h0FFE, assert reset after 1 edge (`salida`=16'h0FFF) → 16'h0000. Release reset and count up one edge → 16'h0001.

Source files
------------

// File: rtl/contador_16b.sv
// contador_16b: 16-bit modal up/down counter built from four cascaded 4-bit stages.
// Each stage reports its own carry/borrow as a registered one-cycle pulse.

// One 4-bit slice of the cascade: a plain adder with carry in and carry out.
module contador_16b_etapa (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] suma,
   output logic       cout
);
   logic [4:0] total;

   assign total = 5'(a) + 5'(b) + 5'(cin);
   assign suma  = total[3:0];
   assign cout  = total[4];
endmodule

module contador_16b (
   input  logic        CLK,
   input  logic        RESET_L,
   input  logic        ENB,
   input  logic [1:0]  MODO,
   input  logic [15:0] entrada,
   output logic [15:0] salida,
   output logic        RCO,
   output logic        RCO162,
   output logic        RCO163,
   output logic        RCO164
);
   localparam int unsigned ANCHO       = 16;
   localparam int unsigned ANCHO_ETAPA = 4;
   localparam int unsigned ETAPAS      = ANCHO / ANCHO_ETAPA;

   typedef enum logic [1:0] {
      MODO_SUBE  = 2'b00,
      MODO_BAJA1 = 2'b01,
      MODO_BAJA3 = 2'b10,
      MODO_CARGA = 2'b11
   } modo_t;

   modo_t              modo_c;
   logic [ANCHO-1:0]   operando_c;
   logic [ANCHO-1:0]   suma_c;
   logic [ETAPAS:0]    acarreo_c;
   logic               resta_c;
   logic [ETAPAS-1:0]  rco_c;

   logic [ANCHO-1:0]   cuenta_q;
   logic [ETAPAS-1:0]  rco_q;

   assign modo_c = modo_t'(MODO);

   // Subtraction is done as addition of the two's complement; a missing carry is a borrow.
   always_comb begin
      operando_c = '0;
      resta_c    = 1'b0;
      case (modo_c)
         MODO_SUBE:  begin operando_c = ANCHO'(16'h0001); resta_c = 1'b0; end
         MODO_BAJA1: begin operando_c = ANCHO'(16'hFFFF); resta_c = 1'b1; end
         MODO_BAJA3: begin operando_c = ANCHO'(16'hFFFD); resta_c = 1'b1; end
         MODO_CARGA: begin operando_c = '0;               resta_c = 1'b0; end
         default:    begin operando_c = '0;               resta_c = 1'b0; end
      endcase
   end

   assign acarreo_c[0] = 1'b0;

   for (genvar k = 0; k < ETAPAS; k++) begin : g_etapa
      contador_16b_etapa u_etapa (
         .a    (cuenta_q[k*ANCHO_ETAPA +: ANCHO_ETAPA]),
         .b    (operando_c[k*ANCHO_ETAPA +: ANCHO_ETAPA]),
         .cin  (acarreo_c[k]),
         .suma (suma_c[k*ANCHO_ETAPA +: ANCHO_ETAPA]),
         .cout (acarreo_c[k+1])
      );
      assign rco_c[k] = acarreo_c[k+1] ^ resta_c;
   end

   always_ff @(posedge CLK or negedge RESET_L) begin
      if (!RESET_L) begin
         cuenta_q <= '0;
         rco_q    <= '0;
      end else if (ENB) begin
         if (modo_c == MODO_CARGA) begin
            cuenta_q <= entrada;
            rco_q    <= '0;
         end else begin
            cuenta_q <= suma_c;
            rco_q    <= rco_c;
         end
      end else begin
         rco_q <= '0;
      end
   end

   assign salida = cuenta_q;
   assign RCO    = rco_q[0];
   assign RCO162 = rco_q[1];
   assign RCO163 = rco_q[2];
   assign RCO164 = rco_q[3];
endmodule

// File: tb/tb_contador_16b.sv
// Scoreboard bench for contador_16b: driver pushes model predictions, monitor pops and compares.
module tb_contador_16b;
   logic        CLK;
   logic        RESET_L;
   logic        ENB;
   logic [1:0]  MODO;
   logic [15:0] entrada;
   logic [15:0] salida;
   logic        RCO, RCO162, RCO163, RCO164;

   typedef struct {
      logic [15:0] v;
      logic [3:0]  f;
      string       nombre;
   } esperado_t;

   esperado_t exp_q[$];
   int        n_comp = 0;
   int        n_fail = 0;
   int        modelo = 0;

   contador_16b dut (
      .CLK(CLK), .RESET_L(RESET_L), .ENB(ENB), .MODO(MODO), .entrada(entrada),
      .salida(salida), .RCO(RCO), .RCO162(RCO162), .RCO163(RCO163), .RCO164(RCO164)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk(input string nombre, input logic [15:0] v, input logic [3:0] f);
      logic [3:0] fl;
      fl = {RCO164, RCO163, RCO162, RCO};
      n_comp++;
      if (salida !== v || fl !== f) begin
         n_fail++;
         $display("FAIL %s: got salida=%h flags=%b, want salida=%h flags=%b",
                  nombre, salida, fl, v, f);
      end
   endtask

   // Reference: plain modular arithmetic; flags from the low 4(k+1) bits of the old value.
   task automatic step(input logic e, input logic [1:0] m, input logic [15:0] d,
                       input string nombre);
      esperado_t x;
      int mask, low, nuevo;
      logic [3:0] f;
      @(negedge CLK);
      ENB = e; MODO = m; entrada = d;
      f = 4'b0000;
      nuevo = modelo;
      if (e) begin
         for (int k = 0; k < 4; k++) begin
            mask = (1 << (4*k + 4)) - 1;
            low  = modelo & mask;
            case (m)
               2'd0: f[k] = (low == mask);
               2'd1: f[k] = (low == 0);
               2'd2: f[k] = (low < 3);
               default: f[k] = 1'b0;
            endcase
         end
         case (m)
            2'd0: nuevo = (modelo + 1) % 65536;
            2'd1: nuevo = (modelo + 65535) % 65536;
            2'd2: nuevo = (modelo + 65533) % 65536;
            default: nuevo = int'(d);
         endcase
      end
      x.v = 16'(nuevo); x.f = f; x.nombre = nombre;
      exp_q.push_back(x);
      modelo = nuevo;
   endtask

   // Monitor: outputs are registered, so every edge after a driven step presents a result.
   always @(posedge CLK) begin
      #1;
      if (exp_q.size() > 0) begin
         esperado_t x;
         x = exp_q.pop_front();
         chk(x.nombre, x.v, x.f);
      end
   end

   // Asynchronous reset mid-cycle, checked before the next edge and while held.
   task automatic reset_medio(input string nombre);
      @(posedge CLK);
      #3;
      ENB = 1'b0;
      RESET_L = 1'b0;
      #1;
      chk({nombre, "_async"}, 16'h0000, 4'b0000);
      repeat (2) begin
         @(posedge CLK); #2;
         chk({nombre, "_held"}, 16'h0000, 4'b0000);
      end
      @(negedge CLK);
      RESET_L = 1'b1;
      modelo = 0;
   endtask

   initial begin
      logic [15:0] especiales [6];
      int drenaje;
      especiales[0] = 16'hFFFF; especiales[1] = 16'h0000; especiales[2] = 16'h0001;
      especiales[3] = 16'h0002; especiales[4] = 16'h00FF; especiales[5] = 16'h0FFF;

      RESET_L = 1'b0; ENB = 1'b0; MODO = 2'd0; entrada = 16'h0;
      #12;
      chk("reset_init", 16'h0000, 4'b0000);
      @(negedge CLK);
      RESET_L = 1'b1;

      step(1, 2'd0, 16'h0, "first_up");
      step(1, 2'd3, 16'h5A5A, "load_5a5a");
      reset_medio("reset_5a5a");

      step(1, 2'd3, 16'h00FF, "load_00ff");
      step(1, 2'd0, 16'h0,    "up_00ff");
      step(1, 2'd0, 16'h0,    "up_0100");
      step(1, 2'd3, 16'hFFFF, "load_ffff");
      step(1, 2'd0, 16'h0,    "up_wrap");
      step(1, 2'd3, 16'h0000, "load_0000");
      step(1, 2'd1, 16'h0,    "down1_wrap");
      step(1, 2'd3, 16'h0010, "load_0010");
      step(1, 2'd2, 16'h0,    "down3_0010");
      step(1, 2'd3, 16'h0002, "load_0002");
      step(1, 2'd2, 16'h0,    "down3_wrap");
      step(1, 2'd3, 16'h0001, "load_0001");
      step(1, 2'd2, 16'h0,    "down3_0001");

      step(1, 2'd3, 16'h1234, "load_1234");
      for (int m = 0; m < 4; m++)
         repeat (5) step(0, 2'(m), 16'hBEEF, "hold");
      step(1, 2'd0, 16'h0, "reenable_up");

      step(1, 2'd3, 16'h0FFE, "load_0ffe");
      step(1, 2'd0, 16'h0,    "up_0ffe");
      reset_medio("reset_count");
      step(1, 2'd0, 16'h0,    "up_after_reset");

      for (int i = 0; i < 3000; i++) begin
         logic [15:0] d;
         d = ($urandom_range(0, 3) == 0) ? especiales[$urandom_range(0, 5)] : 16'($urandom);
         step(($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)), d, "random");
      end

      drenaje = 0;
      while (exp_q.size() > 0 && drenaje < 10) begin
         @(posedge CLK); #2;
         drenaje++;
      end
      n_comp++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending, want 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_comp, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want completion");
      $fatal(1, "timeout");
   end
endmodule
